multicycle_ctrl: RTL and testbench

- Multi-cycle MIPS control unit; successor to the single-cycle decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives a shared-memory multi-cycle datapath and waits on a memory-ready handshake, so memory latency is variable.
- Adds a memory-timeout error path and optional performance counters.

---
 rtl/mc_ctrl_pkg.sv | 43 ++++
 rtl/mc_wait_timer.sv | 25 ++
 rtl/multicycle_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, state encodings and control-field codes for the multi-cycle MIPS controller
package mc_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_ERR       = 4'd15
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts memory wait cycles and flags a timeout when the count reaches MEM_TIMEOUT
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);
    localparam int W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;

    // a clear (memory ready) in the same cycle always beats the timeout
    assign o_timeout = (MEM_TIMEOUT != 0) && i_en && !i_clr && (r_cnt == W'(MEM_TIMEOUT));
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM with memory handshake/timeout; MC_PERF_CNT_EN adds perf counters
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter bit AUTO_START  = 1'b0
`ifdef MC_PERF_CNT_EN
    ,parameter int CNT_W = 32
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       busy_o,
    output logic [1:0] err_o,
    output logic [3:0] state_o
`ifdef MC_PERF_CNT_EN
    ,output logic [CNT_W-1:0] cycle_cnt_o
    ,output logic [CNT_W-1:0] instr_cnt_o
    ,output logic [CNT_W-1:0] stall_cnt_o
`endif
);
    state_t     r_state;
    state_t     w_next;
    state_t     w_bound;
    logic [1:0] r_err;
    logic       r_first;
    logic       w_wait;
    logic       w_timeout;

    assign w_wait  = r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    assign w_bound = start_i ? S_FETCH : S_IDLE;

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_clr    (!w_wait || mem_ready_i),
        .i_en     (w_wait),
        .o_timeout(w_timeout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = (start_i || (AUTO_START && r_first)) ? S_FETCH : S_IDLE;
            S_FETCH:     w_next = mem_ready_i ? S_DECODE : w_timeout ? S_ERR : S_FETCH;
            S_DECODE:
                case (op_i)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_R_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default:      w_next = S_ERR;
                endcase
            S_MEM_ADDR:  w_next = (op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    w_next = mem_ready_i ? S_MEM_WB : w_timeout ? S_ERR : S_MEM_RD;
            S_MEM_WR:    w_next = mem_ready_i ? w_bound : w_timeout ? S_ERR : S_MEM_WR;
            S_R_EXEC:    w_next = S_R_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_next = w_bound;
            default:     w_next = S_ERR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_err   <= ERR_NONE;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            r_state <= w_next;
            if (r_state == S_DECODE && w_next == S_ERR)
                r_err <= ERR_ILLEGAL;
            else if (w_timeout && w_next == S_ERR)
                r_err <= ERR_TIMEOUT;
        end

    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = PC_ALU;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_RT;
        alu_op_o     = ALU_ADD;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                alu_src_b_o = SRCB_FOUR;
            end
            S_DECODE:    alu_src_b_o = SRCB_IMM_SH;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_SUB;
                pc_src_o    = PC_ALUOUT;
                pc_write_o  = zero_i;
            end
            S_JUMP: begin
                pc_src_o   = PC_JUMP;
                pc_write_o = 1'b1;
            end
            S_ADDI_WB:   reg_write_o = 1'b1;
            default:     ;
        endcase
    end

    assign busy_o  = (r_state != S_IDLE) && (r_state != S_ERR);
    assign err_o   = r_err;
    assign state_o = r_state;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_done;

    // an instruction retires when a non-fetch state hands over to FETCH or IDLE
    assign w_done = (w_next == S_FETCH || w_next == S_IDLE) && r_state != S_IDLE && r_state != S_FETCH;

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (busy_o)
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_done)
                r_instr_cnt <= r_instr_cnt + 1'b1;
            if (w_wait && !mem_ready_i)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end

    assign cycle_cnt_o = r_cycle_cnt;
    assign instr_cnt_o = r_instr_cnt;
    assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench comparing per-cycle state and control outputs of multicycle_ctrl
module tb_multicycle_ctrl;
    import mc_ctrl_pkg::*;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic [5:0] op_i = '0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
    logic [1:0] pc_src_o, alu_src_b_o, alu_op_o, err_o;
    logic       alu_src_a_o, reg_dst_o, mem_to_reg_o, reg_write_o, busy_o;
    logic [3:0] state_o;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_o, instr_cnt_o, stall_cnt_o;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(15), .AUTO_START(1'b0)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
        .busy_o(busy_o), .err_o(err_o), .state_o(state_o)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

    typedef struct packed {
        logic       s;
        logic [5:0] op;
        logic       z;
        logic       r;
        state_t     st;
        logic [1:0] e;
    } row_t;

    row_t        rows[$];
    logic [21:0] sb[$];
    logic [21:0] exp_v;
    logic [21:0] obs;
    int          checks = 0;
    int          errors = 0;

    assign obs = {state_o, mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o, alu_src_a_o,
                  alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o, reg_write_o, busy_o, err_o};

    function automatic logic [21:0] exp_vec(input state_t st, input logic r, input logic z, input logic [1:0] e);
        logic req, we, io, ir, pcw, a, dst, m2r, rw, busy;
        logic [1:0] src, b, op;
        {req, we, io, ir, pcw, a, dst, m2r, rw} = '0;
        {src, b, op} = '0;
        busy = (st != S_IDLE) && (st != S_ERR);
        case (st)
            S_FETCH:     begin req = 1; ir = r; pcw = r; b = 2'b01; end
            S_DECODE:    b = 2'b11;
            S_MEM_ADDR:  begin a = 1; b = 2'b10; end
            S_MEM_RD:    begin req = 1; io = 1; end
            S_MEM_WB:    begin m2r = 1; rw = 1; end
            S_MEM_WR:    begin req = 1; we = 1; io = 1; end
            S_R_EXEC:    begin a = 1; op = 2'b10; end
            S_R_WB:      begin dst = 1; rw = 1; end
            S_BRANCH:    begin a = 1; op = 2'b01; src = 2'b01; pcw = z; end
            S_JUMP:      begin src = 2'b10; pcw = 1; end
            S_ADDI_EXEC: begin a = 1; b = 2'b10; end
            S_ADDI_WB:   rw = 1;
            default:     ;
        endcase
        return {st, req, we, io, ir, pcw, src, a, b, op, dst, m2r, rw, busy, e};
    endfunction

    task automatic add(input logic s, input logic [5:0] op, input logic z, input logic r, input state_t st,
                       input logic [1:0] e = 2'b00);
        rows.push_back('{s, op, z, r, st, e});
    endtask

    task automatic add_n(input int n, input logic s, input logic [5:0] op, input logic r, input state_t st,
                         input logic [1:0] e = 2'b00);
        for (int k = 0; k < n; k++)
            add(s, op, 1'b0, r, st, e);
    endtask

    task automatic drive_row(input row_t rw);
        @(negedge clk);
        start_i = rw.s;
        op_i = rw.op;
        zero_i = rw.z;
        mem_ready_i = rw.r;
        sb.push_back(exp_vec(rw.st, rw.r, rw.z, rw.e));
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b0;
        start_i = 1'b0;
        mem_ready_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        start_i = 1'b1;
        mem_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs !== exp_vec(S_IDLE, 1'b1, 1'b0, 2'b00)) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", obs, exp_vec(S_IDLE, 1'b1, 1'b0, 2'b00));
        end
        start_i = 1'b0;
        mem_ready_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        add_n(2, 1'b0, LW, 1'b0, S_IDLE);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reset[%0d]: got %h expected %h", i, obs, exp_v); end
        end
        rows.delete();
    endtask

    task automatic test_lw();
        add(1, LW, 0, 0, S_IDLE);
        add_n(3, 1, LW, 0, S_FETCH);
        add(1, LW, 0, 1, S_FETCH);
        add(1, LW, 0, 1, S_DECODE);
        add(1, LW, 0, 1, S_MEM_ADDR);
        add_n(3, 1, LW, 0, S_MEM_RD);
        add(1, LW, 0, 1, S_MEM_RD);
        add(0, LW, 0, 0, S_MEM_WB);
        add(0, LW, 0, 0, S_IDLE);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL lw[%0d]: got %h expected %h", i, obs, exp_v); end
        end
        rows.delete();
    endtask

    task automatic test_branch();
        add(1, BEQ, 0, 0, S_IDLE);
        add(1, BEQ, 0, 1, S_FETCH);
        add(1, BEQ, 0, 0, S_DECODE);
        add(1, BEQ, 1, 0, S_BRANCH);
        add(1, BEQ, 0, 1, S_FETCH);
        add(1, BEQ, 1, 0, S_DECODE);
        add(0, BEQ, 0, 0, S_BRANCH);
        add(0, BEQ, 0, 0, S_IDLE);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL beq[%0d]: got %h expected %h", i, obs, exp_v); end
        end
        rows.delete();
    endtask

    task automatic test_start_stop();
        add(1, RT, 0, 0, S_IDLE);
        add(1, RT, 0, 1, S_FETCH);
        add(1, RT, 0, 0, S_DECODE);
        add(0, RT, 0, 0, S_R_EXEC);
        add(0, RT, 0, 1, S_R_WB);
        add(0, RT, 0, 0, S_IDLE);
        add(1, ADDI, 0, 0, S_IDLE);
        add(1, ADDI, 0, 1, S_FETCH);
        add(1, ADDI, 0, 0, S_DECODE);
        add(1, ADDI, 0, 0, S_ADDI_EXEC);
        add(1, ADDI, 0, 0, S_ADDI_WB);
        add(1, JMP, 0, 1, S_FETCH);
        add(1, JMP, 0, 0, S_DECODE);
        add(0, JMP, 0, 0, S_JUMP);
        add(0, JMP, 0, 0, S_IDLE);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL start_stop[%0d]: got %h expected %h", i, obs, exp_v); end
        end
        rows.delete();
    endtask

    task automatic test_illegal();
        add(1, BAD, 0, 0, S_IDLE);
        add(1, BAD, 0, 1, S_FETCH);
        add(1, BAD, 0, 0, S_DECODE);
        add_n(3, 1, BAD, 1, S_ERR, 2'b01);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL illegal[%0d]: got %h expected %h", i, obs, exp_v); end
        end
        rows.delete();
        do_reset();
    endtask

    task automatic test_timeout();
        add(1, SW, 0, 0, S_IDLE);
        add(1, SW, 0, 1, S_FETCH);
        add(1, SW, 0, 0, S_DECODE);
        add(1, SW, 0, 0, S_MEM_ADDR);
        add_n(16, 1, SW, 0, S_MEM_WR);
        add_n(3, 1, SW, 1, S_ERR, 2'b10);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL timeout[%0d]: got %h expected %h", i, obs, exp_v); end
        end
        rows.delete();
        do_reset();
    endtask

    task automatic test_ready_wins();
        add(1, SW, 0, 0, S_IDLE);
        add(1, SW, 0, 1, S_FETCH);
        add(1, SW, 0, 0, S_DECODE);
        add(1, SW, 0, 0, S_MEM_ADDR);
        add_n(15, 1, SW, 0, S_MEM_WR);
        add(0, SW, 0, 1, S_MEM_WR);
        add_n(2, 0, SW, 0, S_IDLE);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL ready_wins[%0d]: got %h expected %h", i, obs, exp_v); end
        end
        rows.delete();
    endtask

    task automatic test_async_reset();
        add(1, LW, 0, 0, S_IDLE);
        add(1, LW, 0, 1, S_FETCH);
        add(1, LW, 0, 0, S_DECODE);
        add(1, LW, 0, 0, S_MEM_ADDR);
        add(1, LW, 0, 1, S_MEM_RD);
        add(1, LW, 0, 0, S_MEM_WB);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL async_rst[%0d]: got %h expected %h", i, obs, exp_v); end
        end
        rows.delete();
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if (obs !== exp_vec(S_IDLE, 1'b0, 1'b0, 2'b00)) begin
            errors++;
            $display("FAIL async_rst_drop: got %h expected %h", obs, exp_vec(S_IDLE, 1'b0, 1'b0, 2'b00));
        end
        @(negedge clk);
        rst_i = 1'b1;
    endtask

`ifdef MC_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        #1;
        checks++;
        if ({cycle_cnt_o, instr_cnt_o, stall_cnt_o} !== 96'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d/%0d/%0d expected 0/0/0", cycle_cnt_o, instr_cnt_o, stall_cnt_o);
        end
        add(1, ADDI, 0, 0, S_IDLE);
        add(1, ADDI, 0, 1, S_FETCH);
        add(1, ADDI, 0, 0, S_DECODE);
        add(1, ADDI, 0, 0, S_ADDI_EXEC);
        add(1, ADDI, 0, 0, S_ADDI_WB);
        add(1, JMP, 0, 1, S_FETCH);
        add(1, JMP, 0, 0, S_DECODE);
        add(0, JMP, 0, 0, S_JUMP);
        add(0, JMP, 0, 0, S_IDLE);
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL perf_seq[%0d]: got %h expected %h", i, obs, exp_v); end
        end
        rows.delete();
        checks++;
        if (instr_cnt_o !== 32'd2) begin errors++; $display("FAIL perf_instr: got %0d expected 2", instr_cnt_o); end
        checks++;
        if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL perf_stall: got %0d expected 0", stall_cnt_o); end
        checks++;
        if (cycle_cnt_o !== 32'd7) begin errors++; $display("FAIL perf_cycle: got %0d expected 7", cycle_cnt_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_branch();
        test_start_stop();
        test_illegal();
        test_timeout();
        test_ready_wins();
        test_async_reset();
`ifdef MC_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
